// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: IF/DE pipeline register with load-use hazard detection
// and a stall sequencer that drives fetch PC enable and DE/EX bubble requests.
module fetch_decode_stage #(
    parameter int                  XLEN       = 32,
    parameter logic [XLEN-1:0]     NOP_INSTR  = 32'h00000013,
    parameter int                  LOAD_STALL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] inst_fe,
    input  logic [XLEN-1:0] pc_fe,
    input  logic [XLEN-1:0] pcinc_fe,
    input  logic            NextPCSrc,
    input  logic            RuWr_ex,
    input  logic            isload_ex,
    input  logic [4:0]      rd_ex,
    output logic [XLEN-1:0] inst_de,
    output logic [XLEN-1:0] pc_de,
    output logic [XLEN-1:0] pcinc_de,
    output logic            valid_de,
    output logic            pc_en,
    output logic            clr_de
);
    typedef enum logic {RUN, STALL} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] inst_q, inst_d, pc_q, pc_d, pcinc_q, pcinc_d;
    logic            valid_q, valid_d;
    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2;
    logic            rs1_used, rs2_used, hazard, stall;

    assign opcode   = inst_q[6:0];
    assign rs1      = inst_q[19:15];
    assign rs2      = inst_q[24:20];
    assign rs1_used = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
    assign rs2_used = opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011;
    assign hazard   = valid_q && isload_ex && RuWr_ex && (rd_ex != 5'd0) &&
                      ((rs1_used && rs1 == rd_ex) || (rs2_used && rs2 == rd_ex));
    // STALL stalls unconditionally: EX holds a bubble, so no hazard is re-checked there
    assign stall    = (state_q == RUN) ? hazard : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            inst_q  <= NOP_INSTR;
            pc_q    <= '0;
            pcinc_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            pcinc_q <= pcinc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = NextPCSrc          ? RUN :
                  (state_q == RUN)   ? ((hazard && LOAD_STALL > 1) ? STALL : RUN) :
                  (cnt_q == 2'd1)    ? RUN : STALL;
        cnt_d   = NextPCSrc          ? 2'd0 :
                  (state_q == RUN)   ? ((hazard && LOAD_STALL > 1) ? 2'(LOAD_STALL - 1) : 2'd0) :
                  cnt_q - 2'd1;
        inst_d  = NextPCSrc ? NOP_INSTR : stall ? inst_q  : inst_fe;
        pc_d    = NextPCSrc ? '0        : stall ? pc_q    : pc_fe;
        pcinc_d = NextPCSrc ? '0        : stall ? pcinc_q : pcinc_fe;
        valid_d = NextPCSrc ? 1'b0      : stall ? valid_q : 1'b1;
    end

    always_comb begin
        pc_en  = rst_n && (!stall || NextPCSrc);
        clr_de = !rst_n || (stall && !NextPCSrc);
    end

    assign inst_de  = inst_q;
    assign pc_de    = pc_q;
    assign pcinc_de = pcinc_q;
    assign valid_de = valid_q;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed checks of two stage instances (LOAD_STALL 1 and 3)
// sharing one stimulus stream.
module tb_fetch_decode_stage;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] ADDI = 32'h00500293;
    localparam logic [31:0] LUI  = 32'h123452B7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_fe, pc_fe, pcinc_fe;
    logic        next_pc_src, ru_wr_ex, isload_ex;
    logic [4:0]  rd_ex;
    logic [31:0] o1_inst, o1_pc, o1_pcinc, o3_inst, o3_pc, o3_pcinc;
    logic        o1_valid, o1_pcen, o1_clr, o3_valid, o3_pcen, o3_clr;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fetch_decode_stage #(.LOAD_STALL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .inst_fe(inst_fe), .pc_fe(pc_fe), .pcinc_fe(pcinc_fe),
        .NextPCSrc(next_pc_src), .RuWr_ex(ru_wr_ex), .isload_ex(isload_ex), .rd_ex(rd_ex),
        .inst_de(o1_inst), .pc_de(o1_pc), .pcinc_de(o1_pcinc), .valid_de(o1_valid),
        .pc_en(o1_pcen), .clr_de(o1_clr)
    );

    fetch_decode_stage #(.LOAD_STALL(3)) u3 (
        .clk(clk), .rst_n(rst_n), .inst_fe(inst_fe), .pc_fe(pc_fe), .pcinc_fe(pcinc_fe),
        .NextPCSrc(next_pc_src), .RuWr_ex(ru_wr_ex), .isload_ex(isload_ex), .rd_ex(rd_ex),
        .inst_de(o3_inst), .pc_de(o3_pc), .pcinc_de(o3_pcinc), .valid_de(o3_valid),
        .pc_en(o3_pcen), .clr_de(o3_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic [31:0] i, input logic [31:0] pc);
        inst_fe  = i;
        pc_fe    = pc;
        pcinc_fe = pc + 32'd4;
    endtask

    task automatic ex(input logic ld, input logic wr, input logic [4:0] rd);
        isload_ex = ld;
        ru_wr_ex  = wr;
        rd_ex     = rd;
    endtask

    task automatic both_ctl(input string tag, input logic pcen, input logic clr);
        check({tag, " u1 pc_en"}, 32'(o1_pcen), 32'(pcen));
        check({tag, " u1 clr"},   32'(o1_clr),  32'(clr));
        check({tag, " u3 pc_en"}, 32'(o3_pcen), 32'(pcen));
        check({tag, " u3 clr"},   32'(o3_clr),  32'(clr));
    endtask

    task automatic both_reg(input string tag, input logic [31:0] i, input logic [31:0] pc, input logic v);
        check({tag, " u1 inst"},  o1_inst,  i);
        check({tag, " u1 pc"},    o1_pc,    pc);
        check({tag, " u1 valid"}, 32'(o1_valid), 32'(v));
        check({tag, " u3 inst"},  o3_inst,  i);
        check({tag, " u3 pc"},    o3_pc,    pc);
        check({tag, " u3 valid"}, 32'(o3_valid), 32'(v));
    endtask

    initial begin
        rst_n = 1'b0;
        next_pc_src = 1'b0;
        ex(1'b0, 1'b0, 5'd0);
        ctl(32'hDEADBEEF, 32'h0);
        tick();
        tick();
        both_reg("reset", NOP, 32'h0, 1'b0);
        both_ctl("reset", 1'b0, 1'b1);
        rst_n = 1'b1;
        ctl(ADD, 32'h100);
        #1 both_ctl("run idle", 1'b1, 1'b0);
        tick();
        both_reg("first load", ADD, 32'h100, 1'b1);
        check("first pcinc", o1_pcinc, 32'h104);
        // load-use on rs1: u1 bubbles once, u3 three times
        ex(1'b1, 1'b1, 5'd1);
        ctl(ADDI, 32'h104);
        #1 both_ctl("hazard rs1", 1'b0, 1'b1);
        tick();
        ex(1'b0, 1'b0, 5'd0);
        #1;
        check("u1 release pc_en", 32'(o1_pcen), 32'd1);
        check("u1 release clr", 32'(o1_clr), 32'd0);
        check("u1 held inst", o1_inst, ADD);
        check("u3 stall2 pc_en", 32'(o3_pcen), 32'd0);
        check("u3 stall2 clr", 32'(o3_clr), 32'd1);
        tick();
        check("u1 next inst", o1_inst, ADDI);
        check("u1 next pc", o1_pc, 32'h104);
        check("u3 stall3 clr", 32'(o3_clr), 32'd1);
        check("u3 stall3 pc_en", 32'(o3_pcen), 32'd0);
        check("u3 stall3 inst", o3_inst, ADD);
        tick();
        check("u3 run clr", 32'(o3_clr), 32'd0);
        check("u3 run pc_en", 32'(o3_pcen), 32'd1);
        check("u3 run inst", o3_inst, ADD);
        tick();
        check("u3 next inst", o3_inst, ADDI);
        check("u3 next pcinc", o3_pcinc, 32'h108);
        // false hazards: addi rs2 field, rd x0, lui rs1 field, RuWr_ex low
        ex(1'b1, 1'b1, 5'd5);
        #1 both_ctl("addi rs2 field", 1'b1, 1'b0);
        ex(1'b1, 1'b1, 5'd0);
        #1 both_ctl("rd x0", 1'b1, 1'b0);
        ex(1'b0, 1'b0, 5'd0);
        ctl(LUI, 32'h108);
        tick();
        both_reg("lui load", LUI, 32'h108, 1'b1);
        ex(1'b1, 1'b1, 5'd8);
        #1 both_ctl("lui rs1 field", 1'b1, 1'b0);
        ex(1'b0, 1'b0, 5'd0);
        ctl(ADD, 32'h10C);
        tick();
        ex(1'b1, 1'b0, 5'd1);
        #1 both_ctl("no RuWr", 1'b1, 1'b0);
        ex(1'b1, 1'b1, 5'd2);
        #1 both_ctl("hazard rs2", 1'b0, 1'b1);
        // flush wins over a live hazard
        next_pc_src = 1'b1;
        #1 both_ctl("flush prio", 1'b1, 1'b0);
        tick();
        both_reg("flush prio", NOP, 32'h0, 1'b0);
        next_pc_src = 1'b0;
        #1 both_ctl("nop no hazard", 1'b1, 1'b0);
        tick();
        both_reg("after flush", ADD, 32'h10C, 1'b1);
        // flush in the second stall cycle of u3
        ex(1'b1, 1'b1, 5'd1);
        #1 both_ctl("hazard again", 1'b0, 1'b1);
        tick();
        ex(1'b0, 1'b0, 5'd0);
        next_pc_src = 1'b1;
        #1 both_ctl("flush in stall", 1'b1, 1'b0);
        tick();
        next_pc_src = 1'b0;
        #1;
        both_reg("stall flushed", NOP, 32'h0, 1'b0);
        both_ctl("stall flushed", 1'b1, 1'b0);
        ctl(ADDI, 32'h200);
        tick();
        both_ctl("no more bubbles", 1'b1, 1'b0);
        both_reg("resume", ADDI, 32'h200, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
